uart_rx_buffer: RTL and testbench

UART receiver for the Basys3 serial link: samples the asynchronous `RX` pin, recovers 8-bit frames (8N1 by default), and pushes each good byte into a 4-entry history buffer `RXBUF` that the seven-segment display pages through. It is the receive-side counterpart of the board's transmitter and sits directly between the `RX` pin and the display logic in the top level.

---
 rtl/uart_rx_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// UART receiver with a 4-deep received-byte history for the display pager.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined; 8N1 otherwise.
module uart_rx_buffer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RX,
    output logic [3:0][7:0] RXBUF,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    output logic [2:0]      rx_count,
    output logic            frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            rx_busy
);

    localparam int OSB = BAUD * OVERSAMPLE;
    localparam int DIV = (CLK_HZ + OSB / 2) / OSB;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_A     = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_B     = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_C     = PW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sync;
    logic            w_rx_s;
    logic [CW-1:0]   r_div;
    logic            w_tick;
    logic [PW-1:0]   r_phase;
    logic            r_s0;
    logic            r_s1;
    logic            w_maj;
    logic            w_dec;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_par_bad;
    logic            w_shift;
    logic            w_par_chk;
    logic            w_accept;
    logic            w_ferr;
    logic            w_perr;

    assign w_rx_s = r_sync[1];
    assign w_tick = (r_div == DIV_LAST);
    assign w_maj  = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    // Decision is made once the third sample of the window is available.
    assign w_dec  = w_tick && (r_phase == PH_C);
    assign rx_busy = (r_state != S_IDLE);

    // Two-flop synchronizer; resets to idle-high so no false start after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], RX};
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    // Bit phase: held at 0 in IDLE, wraps every bit so windows stay aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
        end else if (r_state == S_IDLE) begin
            r_phase <= '0;
        end else if (w_tick) begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        end
    end

    // Capture the first two samples of the majority window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (w_tick) begin
            if (r_phase == PH_A) r_s0 <= w_rx_s;
            if (r_phase == PH_B) r_s1 <= w_rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (!w_rx_s) w_next = S_START;
            S_START: if (w_dec) w_next = w_maj ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_dec && r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_dec) w_next = S_STOP;
`endif
            S_STOP: begin
                if (w_dec) begin
                    if (r_par_bad || w_maj) w_next = S_IDLE;
                    else                    w_next = S_BREAK;
                end
            end
            S_BREAK: if (w_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Per-state decision strobes.
    always_comb begin
        w_shift   = 1'b0;
        w_par_chk = 1'b0;
        w_accept  = 1'b0;
        w_ferr    = 1'b0;
        w_perr    = 1'b0;
        unique case (r_state)
            S_DATA: w_shift = w_dec;
`ifdef UART_RX_PARITY_EN
            S_PARITY: w_par_chk = w_dec;
`endif
            S_STOP: begin
                if (w_dec) begin
                    if (r_par_bad)  w_perr   = 1'b1;
                    else if (w_maj) w_accept = 1'b1;
                    else            w_ferr   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Data shift register, bit index and parity verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit     <= '0;
            r_par_bad <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_bit     <= '0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shift <= {w_maj, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
            if (w_par_chk) r_par_bad <= (w_maj != ^r_shift);
        end
    end

    // History buffer, last byte, saturating count and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RXBUF     <= '0;
            rx_data   <= '0;
            rx_count  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= w_accept;
            frame_err <= w_ferr;
            if (w_accept) begin
                RXBUF   <= {RXBUF[2:0], r_shift};
                rx_data <= r_shift;
                if (rx_count != 3'd4) rx_count <= rx_count + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity failure pulse, issued after the stop-bit sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_err <= 1'b0;
        else        parity_err <= w_perr;
    end
`else
    logic w_unused;
    assign w_unused = w_perr | w_par_chk;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer at a scaled-down baud (160 clk/bit).
// Define UART_RX_PARITY_EN to also exercise the 8E1 parity path.
module tb_uart_rx_buffer;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int OS     = 16;
    localparam int BITC   = CLK_HZ / BAUD;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx;
    logic [3:0][7:0] rxbuf;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [2:0]      rx_count;
    logic            frame_err;
    logic            rx_busy;
    logic            perr;
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    uart_rx_buffer #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .RX(rx),
        .RXBUF(rxbuf),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_count(rx_count),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(perr),
`endif
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic bitx(input logic b, input int n);
        rx = b;
        repeat (n * BITC) @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input logic stop,
                         input logic par);
        bitx(1'b0, 1);
        for (int i = 0; i < 8; i++) bitx(b[i], 1);
`ifdef UART_RX_PARITY_EN
        bitx(par, 1);
`endif
        bitx(stop, 1);
    endtask

    task automatic send(input logic [7:0] b);
        push(0, b);
        frame(b, 1'b1, ^b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rxbuf"}, rxbuf, 32'h0);
        chk({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
        chk({tag, "_rx_count"}, {29'h0, rx_count}, 32'h0);
        chk({tag, "_pulses"}, {29'h0, rx_valid, frame_err, perr}, 32'h0);
        chk({tag, "_rx_busy"}, {31'h0, rx_busy}, 32'h0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err || perr)) begin
            int  k;
            ev_t e;
            chk("pulse_exclusive", {30'h0, rx_valid & frame_err,
                rx_valid & perr}, 32'h0);
            k = rx_valid ? 0 : (frame_err ? 1 : 2);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse_kind", k, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", k, e.kind);
                if (rx_valid) begin
                    chk("rx_data", {24'h0, rx_data}, {24'h0, e.data});
                    chk("rxbuf0", {24'h0, rxbuf[0]}, {24'h0, e.data});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;
        bitx(1'b1, 2);

        send(8'hA5);
        bitx(1'b1, 1);
        chk("a5_rxbuf", rxbuf, 32'h0000_00A5);
        chk("a5_count", {29'h0, rx_count}, 32'd1);

        for (int i = 1; i <= 5; i++) send(8'(i));
        bitx(1'b1, 1);
        chk("b2b_rxbuf", rxbuf, 32'h0203_0405);
        chk("b2b_count", {29'h0, rx_count}, 32'd4);

        push(1, 8'h00);
        frame(8'h3C, 1'b0, ^8'h3C);
        bitx(1'b0, 3);
        bitx(1'b1, 2);
        chk("ferr_rxbuf", rxbuf, 32'h0203_0405);
        chk("ferr_busy", {31'h0, rx_busy}, 32'h0);
        send(8'h11);
        bitx(1'b1, 1);
        chk("after_ferr_rxbuf", rxbuf, 32'h0304_0511);
        chk("sat_count", {29'h0, rx_count}, 32'd4);

        rx = 1'b0;
        repeat (32) @(posedge clk);
        bitx(1'b1, 2);
        chk("glitch_busy", {31'h0, rx_busy}, 32'h0);
        chk("glitch_rxbuf", rxbuf, 32'h0304_0511);

        bitx(1'b0, 1);
        for (int i = 0; i < 4; i++) bitx(i[0], 1);
        rx = 1'b1;
        repeat (BITC / 2) @(posedge clk);
        rst_n = 1'b0;
        #1 chk_zero("midreset");
        repeat (BITC / 2) @(posedge clk);
        for (int i = 5; i < 8; i++) bitx(i[0], 1);
        bitx(1'b1, 2);
        #1 chk_zero("midreset_hold");
        rst_n = 1'b1;
        bitx(1'b1, 1);
        send(8'h7E);
        bitx(1'b1, 1);
        chk("post_reset_rxbuf", rxbuf, 32'h0000_007E);
        chk("post_reset_count", {29'h0, rx_count}, 32'd1);

`ifdef UART_RX_PARITY_EN
        push(2, 8'h00);
        frame(8'h07, 1'b1, 1'b0);
        bitx(1'b1, 1);
        chk("perr_rxbuf", rxbuf, 32'h0000_007E);
        send(8'h07);
        bitx(1'b1, 1);
        chk("par_ok_rxbuf", rxbuf, 32'h0000_7E07);
        chk("par_ok_count", {29'h0, rx_count}, 32'd2);
`endif

        bitx(1'b1, 2);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
